bus_ram_target: RTL and testbench
=================================

# bus_ram_target

Responder (target) end of the bmain bus: accepts the 4-beat line-burst read/write transactions issued by the data-cache stage and fetch initiators, and serves them from an on-chip word-addressed RAM with byte write masks. Sits on the bmain side of the interconnect as a memory endpoint. Out-of-range or malformed transactions are reported on the error/eack pair.

## Interface
- MEM_BASE, 27'h0, word address [28:2] of first RAM word; must be aligned to MEM_WORDS
- MEM_WORDS, 16384, RAM depth in 32-bit words; power of two, at least 4
- clk_core  in  1  core clock
- reset_n  in  1  reset; asynchronous, active-low
- bmain_cvalid  in  1  command valid
- bram_cready  out  1  command ready
- bmain_cmd  in  1  0 = write burst, 1 = read burst
- bmain_addr  in  27  word address [28:2]; bits [3:2] ignored (bursts are line-aligned)
- bmain_wvalid  in  1  write beat valid
- bram_wready  out  1  write beat ready
- bmain_wlast  in  1  final write beat
- bmain_wdata  in  32  write data
- bmain_wmask  in  4  byte enables, bit i covers wdata[8i+7:8i]
- bram_rvalid  out  1  read beat valid
- bmain_rready  in  1  read beat ready
- bram_rlast  out  1  final read beat
- bram_rdata  out  32  read data
- bram_error  out  1  transaction error, held until acknowledged
- bmain_eack  in  1  error acknowledge

## Operation
- States (one-hot): IDLE, WRITE, READ, ERR. Reset → IDLE.
- Burst = 4 beats. Beat k targets word {line[28:4], k}, k = 0..3, in ascending order regardless of addr[3:2].
- IDLE: bram_cready = 1. On cvalid & cready, latch line address and cmd, and clear beat counter.
  - Address outside [MEM_BASE, MEM_BASE+MEM_WORDS) → ERR.
  - cmd = 0 → WRITE.
  - cmd = 1 → READ.
- WRITE: bram_wready = 1. Each wvalid & wready beat writes wdata under wmask, then the counter increments.
  - wlast with counter == 3 → IDLE.
  - wlast with counter != 3, or counter == 3 without wlast → beat discarded (no RAM write), go to ERR.
- READ: issue a RAM read for beat k whenever k ≤ 3 and (FIFO occupancy + in-flight reads) < 2.
  - RAM data lands in a 2-entry read FIFO, each entry tagged last = (k == 3).
  - bram_rvalid = FIFO non-empty; bram_rdata/bram_rlast come from the FIFO head.
  - rvalid & rready pops the head. Popping the last-tagged entry → IDLE.
- ERR: bram_error = 1, all other readies/valids 0. bmain_eack sampled high at a clock edge → IDLE.
- Writes and reads never overlap; one transaction outstanding at a time.
- Reset values: bram_cready = 1 (IDLE), every other output 0, FIFO empty, counter 0. RAM contents are not reset.

## Timing
- Command handshake at cycle T.
- Write: wready from T+1. With wvalid held, beats are accepted T+1..T+4 and cready returns at T+5. RAM write takes effect at the beat's clock edge.
- Read: RAM read issued T+1, first rvalid T+2. With rready held, beats at T+2..T+5, rlast at T+5, cready at T+6.
- RAM read latency is 1 cycle. FIFO depth 2 gives one beat per cycle under continuous rready with no bubbles.
- rready low: rvalid, rdata and rlast stay stable. Issuing stops once occupancy + in-flight = 2, and no read is lost.
- Error:
  - Range error: bram_error asserted from T+1.
  - Framing error: bram_error asserted the cycle after the offending beat.
  - Deassertion: the cycle after the eack edge. The initiator drives eack combinationally from error, so a range error lasts exactly one cycle.
- Async reset mid-burst: immediate return to IDLE, FIFO flushed, in-flight read dropped. Partial write beats already committed remain in RAM.

## Structure
- Shared package: bus command encoding constants (BUS_CMD_WRITE = 0, BUS_CMD_READ = 1) and BUS_BURST_LEN = 4, shared with initiators.
- Sub-module bus_ram_array:
  - single port, synchronous read with 1-cycle latency;
  - 4-bit byte write enable;
  - write and read mutually exclusive per cycle (guaranteed by the FSM).
- Read FIFO and state machine stay inline in bus_ram_target.

## Test plan
- Write burst at 0x100 (addr[28:2] = 0x40), data 0x11111111..0x44444444, wmask 4'hF, wlast on beat 3 → cready back at T+5. Read burst of same line → rdata 0x11111111, 0x22222222, 0x33333333, 0x44444444 on T+2..T+5, rlast on the fourth beat only.
- Byte mask: word 0x40 = 0xAABBCCDD. Write burst with beat 0 wmask 4'b0101, wdata 0x11223344, other beats wmask 0 → readback beat 0 = 0xAA22CC44, other words unchanged.
- Read backpressure: rready toggles 1,0,0,1,1,0,1 → exactly four beats delivered in order, data stable while rvalid & ~rready, no duplicate or lost beat.
- Range error: command with addr = MEM_BASE + MEM_WORDS, eack tied to error → error high one cycle at T+1, no wready/rvalid, cready high at T+2, RAM unchanged.
- Framing: wlast on beat 1 → beat 1 not written (beat 0 written), error asserted the next cycle until eack, then IDLE. Next read burst completes normally.
- Reset_n pulsed low mid-read after 2 beats → rvalid 0 and cready 1 immediately. A fresh read returns correct data from beat 0.

Source files
------------

// File: rtl/bus_ram_target_pkg.sv
// Shared bmain bus definitions: command encoding, burst length, target FSM states and read-beat payload.
package bus_ram_target_pkg;

    localparam logic BUS_CMD_WRITE = 1'b0;
    localparam logic BUS_CMD_READ  = 1'b1;

    localparam int unsigned BUS_BURST_LEN = 4;
    localparam int unsigned BUS_ADDR_W    = 27;
    localparam int unsigned BUS_DATA_W    = 32;
    localparam int unsigned BUS_MASK_W    = BUS_DATA_W / 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_WRITE = 4'b0010,
        ST_READ  = 4'b0100,
        ST_ERR   = 4'b1000
    } bus_state_e;

    typedef struct packed {
        logic [BUS_DATA_W-1:0] data;
        logic                  last;
    } rd_beat_t;

endpackage

// File: rtl/bus_ram_target_if.sv
// bmain bus bundle between an initiator (master) and a memory target (slave).
interface bus_ram_target_if;
    import bus_ram_target_pkg::*;

    logic                  bmain_cvalid;
    logic                  bram_cready;
    logic                  bmain_cmd;
    logic [BUS_ADDR_W-1:0] bmain_addr;
    logic                  bmain_wvalid;
    logic                  bram_wready;
    logic                  bmain_wlast;
    logic [BUS_DATA_W-1:0] bmain_wdata;
    logic [BUS_MASK_W-1:0] bmain_wmask;
    logic                  bram_rvalid;
    logic                  bmain_rready;
    logic                  bram_rlast;
    logic [BUS_DATA_W-1:0] bram_rdata;
    logic                  bram_error;
    logic                  bmain_eack;

    modport master (
        output bmain_cvalid, bmain_cmd, bmain_addr,
        output bmain_wvalid, bmain_wlast, bmain_wdata, bmain_wmask,
        output bmain_rready, bmain_eack,
        input  bram_cready, bram_wready, bram_rvalid, bram_rlast, bram_rdata, bram_error
    );

    modport slave (
        input  bmain_cvalid, bmain_cmd, bmain_addr,
        input  bmain_wvalid, bmain_wlast, bmain_wdata, bmain_wmask,
        input  bmain_rready, bmain_eack,
        output bram_cready, bram_wready, bram_rvalid, bram_rlast, bram_rdata, bram_error
    );

endinterface

// File: rtl/bus_ram_array.sv
// Single-port word RAM with byte write enables and a 1-cycle synchronous read.
module bus_ram_array #(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wmask,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_ram_target.sv
// bmain memory target: 4-beat line bursts served from an on-chip RAM, with range/framing error reporting.
module bus_ram_target
    import bus_ram_target_pkg::*;
#(
    parameter logic [BUS_ADDR_W-1:0] MEM_BASE  = '0,
    parameter int unsigned           MEM_WORDS = 16384
) (
    input logic             clk_core,
    input logic             reset_n,
    bus_ram_target_if.slave bus
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned BW = $clog2(BUS_BURST_LEN);
    localparam logic [BW:0] LAST_BEAT = (BW+1)'(BUS_BURST_LEN - 1);
    localparam logic [BW:0] BURST_END = (BW+1)'(BUS_BURST_LEN);

    bus_state_e               state, state_nx;
    logic [BUS_ADDR_W-BW-1:0] line_q;
    logic [BW:0]              beat_q;
    logic                     cmd_fire, wr_commit, rd_issue;
    logic                     in_range, wr_good;
    logic                     rd_pend, rd_pend_last;
    logic [1:0]               fifo_cnt, occ;
    logic                     wr_ptr, rd_ptr;
    rd_beat_t                 fifo_mem [2];
    rd_beat_t                 head;
    logic                     rvalid_i, pop, pop_fifo, push;
    logic [BUS_ADDR_W-1:0]    word_idx;
    logic [BUS_DATA_W-1:0]    ram_rdata;

    assign in_range = (bus.bmain_addr >> AW) == (MEM_BASE >> AW);
    assign wr_good  = bus.bmain_wlast == (beat_q == LAST_BEAT);
    assign word_idx = {line_q, beat_q[BW-1:0]};
    assign occ      = fifo_cnt + 2'(rd_pend);

    // Head bypasses straight from the RAM output when the FIFO is empty.
    assign head     = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] : {ram_rdata, rd_pend_last};
    assign rvalid_i = (state == ST_READ) && ((fifo_cnt != 2'd0) || rd_pend);
    assign pop      = rvalid_i && bus.bmain_rready;
    assign pop_fifo = pop && (fifo_cnt != 2'd0);
    assign push     = rd_pend && !(pop && (fifo_cnt == 2'd0));

    assign bus.bram_cready = (state == ST_IDLE);
    assign bus.bram_wready = (state == ST_WRITE);
    assign bus.bram_error  = (state == ST_ERR);
    assign bus.bram_rvalid = rvalid_i;
    assign bus.bram_rdata  = head.data;
    assign bus.bram_rlast  = rvalid_i && head.last;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_fire  = 1'b0;
        wr_commit = 1'b0;
        rd_issue  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_fire = bus.bmain_cvalid;
                if (bus.bmain_cvalid) begin
                    if (!in_range)                         state_nx = ST_ERR;
                    else if (bus.bmain_cmd == BUS_CMD_READ) state_nx = ST_READ;
                    else                                   state_nx = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus.bmain_wvalid) begin
                    wr_commit = wr_good;
                    if (!wr_good)             state_nx = ST_ERR;
                    else if (bus.bmain_wlast) state_nx = ST_IDLE;
                end
            end
            ST_READ: begin
                rd_issue = (beat_q < BURST_END) && (occ < 2'd2);
                if (pop && head.last) state_nx = ST_IDLE;
            end
            ST_ERR: begin
                if (bus.bmain_eack) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Burst address/beat tracking, in-flight read and 2-entry read FIFO.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            line_q       <= '0;
            beat_q       <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            fifo_cnt     <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
        end else begin
            if (cmd_fire) begin
                line_q <= bus.bmain_addr[BUS_ADDR_W-1:BW];
                beat_q <= '0;
            end else if (wr_commit || rd_issue) begin
                beat_q <= beat_q + (BW+1)'(1);
            end
            rd_pend      <= rd_issue;
            rd_pend_last <= rd_issue && (beat_q == LAST_BEAT);
            if (push) begin
                fifo_mem[wr_ptr] <= {ram_rdata, rd_pend_last};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_fifo) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop_fifo);
        end
    end

    bus_ram_array #(
        .DEPTH (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk_core),
        .we    (wr_commit),
        .wmask (bus.bmain_wmask),
        .re    (rd_issue),
        .addr  (AW'(word_idx)),
        .wdata (bus.bmain_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_bus_ram_target.sv
// Directed bench for bus_ram_target: word-array memory model, read-beat scoreboard and literal timing checks.
module tb_bus_ram_target;
    import bus_ram_target_pkg::*;

    logic clk_core = 1'b0;
    logic reset_n  = 1'b0;
    logic eack_tie = 1'b1;
    logic eack_man = 1'b0;

    int total = 0;
    int bad   = 0;
    int beats_seen = 0;

    logic [31:0] mdl [16384];
    logic [31:0] exp_data [$];
    logic        exp_last [$];
    logic [31:0] got [4];
    logic        hold_valid = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;

    bus_ram_target_if bus ();

    assign bus.bmain_eack = eack_tie ? bus.bram_error : eack_man;

    bus_ram_target #(
        .MEM_BASE  (27'h0),
        .MEM_WORDS (16384)
    ) dut (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk_core = ~clk_core;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Read-beat scoreboard: every accepted beat must match the model, held beats must stay stable.
    always @(negedge clk_core) begin
        if (!reset_n) begin
            hold_valid = 1'b0;
        end else begin
            if (bus.bram_error)
                check("err_excl", {29'd0, bus.bram_wready, bus.bram_rvalid, bus.bram_cready}, 32'd0);
            if (bus.bram_rvalid) begin
                if (hold_valid) begin
                    check("rdata_stable", bus.bram_rdata, hold_data);
                    check("rlast_stable", bus.bram_rlast, hold_last);
                end
                if (bus.bmain_rready) begin
                    if (exp_data.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        check("rdata", bus.bram_rdata, exp_data.pop_front());
                        check("rlast", bus.bram_rlast, exp_last.pop_front());
                    end
                    if (beats_seen < 4) got[beats_seen] = bus.bram_rdata;
                    beats_seen++;
                    hold_valid = 1'b0;
                end else begin
                    hold_valid = 1'b1;
                    hold_data  = bus.bram_rdata;
                    hold_last  = bus.bram_rlast;
                end
            end else begin
                if (hold_valid) check("rvalid_drop", 0, 1);
                hold_valid = 1'b0;
            end
        end
    end

    task automatic do_cmd(input logic c, input logic [26:0] a);
        int n = 0;
        while (!bus.bram_cready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_cready", bus.bram_cready, 1);
        bus.bmain_cvalid = 1'b1;
        bus.bmain_cmd    = c;
        bus.bmain_addr   = a;
        tick();
        bus.bmain_cvalid = 1'b0;
    endtask

    // Returns at T+1+beats; the model only takes beats whose wlast agrees with beat index 3.
    task automatic write_burst(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m, input int last_at);
        int  base = int'(a & 27'h3FFC);
        logic good;
        do_cmd(BUS_CMD_WRITE, a);
        check("wready_t1", bus.bram_wready, 1);
        for (int k = 0; k < 4; k++) begin
            bus.bmain_wvalid = 1'b1;
            bus.bmain_wdata  = d[32*k +: 32];
            bus.bmain_wmask  = m[4*k +: 4];
            bus.bmain_wlast  = (k == last_at);
            good = ((k == last_at) == (k == 3));
            if (good) mdl[base + k] = merge(mdl[base + k], d[32*k +: 32], m[4*k +: 4]);
            tick();
            if (!good || k == last_at) break;
        end
        bus.bmain_wvalid = 1'b0;
        bus.bmain_wlast  = 1'b0;
    endtask

    task automatic expect_line(input logic [26:0] a);
        int base = int'(a & 27'h3FFC);
        beats_seen = 0;
        for (int k = 0; k < 4; k++) begin
            exp_data.push_back(mdl[base + k]);
            exp_last.push_back(k == 3);
        end
    endtask

    // pat[n] drives rready n cycles after the command; rready is 1 afterwards.
    task automatic read_burst(input logic [26:0] a, input logic [6:0] pat);
        int n = 0;
        expect_line(a);
        bus.bmain_rready = 1'b1;
        do_cmd(BUS_CMD_READ, a);
        while (exp_data.size() != 0 && n < 40) begin
            bus.bmain_rready = (n < 7) ? pat[n] : 1'b1;
            tick();
            n++;
        end
        bus.bmain_rready = 1'b1;
        check("read_done", exp_data.size(), 0);
        tick();
        check("read_beats", beats_seen, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.bmain_cvalid = 1'b0;
        bus.bmain_cmd    = 1'b0;
        bus.bmain_addr   = '0;
        bus.bmain_wvalid = 1'b0;
        bus.bmain_wlast  = 1'b0;
        bus.bmain_wdata  = '0;
        bus.bmain_wmask  = '0;
        bus.bmain_rready = 1'b1;

        repeat (3) tick();
        check("rst_cready", bus.bram_cready, 1);
        check("rst_others", {28'd0, bus.bram_wready, bus.bram_rvalid, bus.bram_rlast, bus.bram_error}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Full write then read of line 0x40 with exact beat timing.
        write_burst(27'h40, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'hFFFF, 3);
        check("wr_t5_cready", bus.bram_cready, 1);
        check("wr_t5_wready", bus.bram_wready, 0);

        expect_line(27'h40);
        do_cmd(BUS_CMD_READ, 27'h40);
        check("rd_t1_rvalid", bus.bram_rvalid, 0);
        tick();
        check("rd_t2_rvalid", bus.bram_rvalid, 1);
        check("rd_t2_rdata", bus.bram_rdata, 32'h11111111);
        check("rd_t2_rlast", bus.bram_rlast, 0);
        tick();
        tick();
        check("rd_t4_rlast", bus.bram_rlast, 0);
        tick();
        check("rd_t5_rdata", bus.bram_rdata, 32'h44444444);
        check("rd_t5_rlast", bus.bram_rlast, 1);
        tick();
        check("rd_t6_cready", bus.bram_cready, 1);
        check("rd_t6_rvalid", bus.bram_rvalid, 0);

        // Byte-mask merge on word 0x40.
        write_burst(27'h40, {32'h88888888, 32'h77777777, 32'h66666666, 32'hAABBCCDD}, 16'hFFFF, 3);
        write_burst(27'h40, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11223344}, 16'h0005, 3);
        read_burst(27'h40, 7'b1111111);
        check("mask_w0", got[0], 32'hAA22CC44);
        check("mask_w1", got[1], 32'h66666666);
        check("mask_w3", got[3], 32'h88888888);

        // Read backpressure: rready 1,0,0,1,1,0,1.
        read_burst(27'h40, 7'b1011001);
        check("bp_w0", got[0], 32'hAA22CC44);
        check("bp_w2", got[2], 32'h77777777);

        // Range error on a command that aliases RAM word 0, with write data offered.
        write_burst(27'h0, {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0}, 16'hFFFF, 3);
        eack_tie = 1'b1;
        bus.bmain_wvalid = 1'b1;
        bus.bmain_wlast  = 1'b1;
        bus.bmain_wdata  = 32'hDEADBEEF;
        bus.bmain_wmask  = 4'hF;
        do_cmd(BUS_CMD_WRITE, 27'd16384);
        check("rng_t1_error", bus.bram_error, 1);
        check("rng_t1_wready", bus.bram_wready, 0);
        check("rng_t1_rvalid", bus.bram_rvalid, 0);
        tick();
        check("rng_t2_error", bus.bram_error, 0);
        check("rng_t2_cready", bus.bram_cready, 1);
        bus.bmain_wvalid = 1'b0;
        bus.bmain_wlast  = 1'b0;
        read_burst(27'h0, 7'b1111111);
        check("rng_ram_w0", got[0], 32'hC0C0C0C0);

        // Framing error: wlast on beat 1, held until a manual eack.
        write_burst(27'h80, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 16'hFFFF, 3);
        eack_tie = 1'b0;
        eack_man = 1'b0;
        write_burst(27'h80, {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0}, 16'hFFFF, 1);
        check("frm_t3_error", bus.bram_error, 1);
        check("frm_t3_wready", bus.bram_wready, 0);
        tick();
        check("frm_hold_error", bus.bram_error, 1);
        eack_man = 1'b1;
        tick();
        eack_man = 1'b0;
        eack_tie = 1'b1;
        check("frm_ack_error", bus.bram_error, 0);
        check("frm_ack_cready", bus.bram_cready, 1);
        read_burst(27'h80, 7'b1111111);
        check("frm_w0", got[0], 32'hB0B0B0B0);
        check("frm_w1", got[1], 32'hA1A1A1A1);

        // Async reset after two delivered beats, then a clean re-read.
        expect_line(27'h80);
        bus.bmain_rready = 1'b1;
        do_cmd(BUS_CMD_READ, 27'h80);
        for (int n = 0; n < 20 && beats_seen < 2; n++) tick();
        check("rst_mid_beats", beats_seen, 2);
        bus.bmain_rready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_mid_rvalid", bus.bram_rvalid, 0);
        check("rst_mid_cready", bus.bram_cready, 1);
        exp_data.delete();
        exp_last.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        read_burst(27'h80, 7'b1111111);
        check("rst_re_w0", got[0], 32'hB0B0B0B0);
        check("rst_re_w3", got[3], 32'hA3A3A3A3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
